// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA_ADDR enqueue bytes, loads from STATUS_ADDR return status.
// Latency: a push accepted while idle drives the start bit one clk later. Backpressure: pushes while full are dropped and set sticky overflow.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  DATA_ADDR    = 8'hFD,
  parameter logic [7:0]  STATUS_ADDR  = 8'hFC,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [7:0] Address,
  input  logic [7:0] RegData,
  output logic [7:0] RdData,
  output logic       tx,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CNTW-1:0] r_count;
  logic            r_ovf;
  logic [1:0]      r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic       w_full;
  logic       w_empty;
  logic       w_baud_end;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head_dat;
  logic [2:0] w_cnt3;
  logic [7:0] w_status;

  always_comb begin
    w_full     = (r_count == CNT_FULL);
    w_empty    = (r_count == '0);
    w_baud_end = (r_baud == BAUD_LAST);
    // Full is judged on the pre-pop count, so a push never rides on a same-cycle pop.
    w_push     = EN && (Address == DATA_ADDR) && !w_full;
    w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
    w_head_dat = r_mem[r_head];
    w_cnt3     = 3'(r_count);
    w_status   = {1'b0, w_cnt3, r_ovf, w_full, w_empty, (r_state != S_IDLE)};
    RdData     = (Address == STATUS_ADDR) ? w_status : 8'h00;
    busy       = (r_state != S_IDLE) || !w_empty;
    tx         = r_tx;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= RegData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (EN && (Address == DATA_ADDR) && w_full) r_ovf <= 1'b1;
      else if (EN && (Address == STATUS_ADDR))    r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head_dat;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud   <= '0;
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          // Stop bit: chain straight into the next start bit when more data is queued.
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head_dat;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter peripheral for the 8-bit single-cycle core. Works alongside the parallel output port: the core sends a byte by issuing a store to DATA_ADDR and polls a status register at STATUS_ADDR through the load path. Bytes are buffered in a small FIFO and serialized 8N1, LSB first, on the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (434 = 115200 baud at 50 MHz); must be >= 2
DATA_ADDR, 8'hFD, store address that pushes a byte into the TX FIFO
STATUS_ADDR, 8'hFC, load address returning status; a store here clears overflow
FIFO_DEPTH, 4, TX FIFO entries; power of 2, range 2..4

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low
EN  input  1  store strobe (MemWrite); integrator guarantees one clk cycle per store
Address  input  8  ALU result / bus address
RegData  input  8  store data (rd2)
RdData  output  8  status byte when Address==STATUS_ADDR, else 8'h00 (combinational)
tx  output  1  serial line, idle high, registered
busy  output  1  high while FSM not IDLE or FIFO not empty

Behaviour:
- Reset (rst=0, asynchronous): tx=1, FSM=IDLE, FIFO empty (count=0), overflow=0, baud and bit counters=0, busy=0, RdData at STATUS_ADDR=8'h02.
- Reset mid-frame: frame aborted, tx returns high immediately, FIFO contents discarded.
- Push: EN=1 && Address==DATA_ADDR && !full, sampled at the clk edge, writes RegData at the tail; count+1.
- Full rule: full is evaluated before any same-cycle pop. A push while full is dropped, FIFO is unchanged, and overflow is set (sticky).
- Overflow clear: EN=1 && Address==STATUS_ADDR clears overflow at that edge. RegData is ignored. If an overflowing push and a clear land in the same cycle, the clear has no effect because the addresses differ; nothing needs arbitrating.
- Stores to any other address, and address matches with EN=0, have no effect.
- Status byte: bit7=0, bits[6:4]=count (0..FIFO_DEPTH), bit3=overflow, bit2=full, bit1=empty, bit0=FSM!=IDLE.
- FSM:
  - IDLE: tx=1. If FIFO non-empty: pop head into the shift register, go to START, and drive tx=0 at the same edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles; shift right after each bit; after 8 bits go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop and go directly to START. No idle gap; frames are back-to-back.
    - FIFO empty: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: a push accepted at edge E0 while IDLE gives tx=0 after edge E1.
- Baud counter: counts 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT), wrapping to 0 at each bit boundary. Bit counter: 3 bits, wraps 7->0.
- Simultaneous push and pop (not full): both occur and count is unchanged. Head/tail pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Reset check: hold rst=0 and apply stray strobes -> tx=1, busy=0, Address=FC gives RdData=8'h02. After release with no stores, tx stays 1 for 100 cycles.
2. Single byte, CLKS_PER_BIT=4: store 8'h55 to FD at E0 -> tx=0 for cycles 1-4, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles. That is 40 cycles total; afterwards status=8'h02 and busy=0.
3. Burst and overflow: stores A1..A6 to FD on consecutive cycles from IDLE -> A1 popped at E1; after E4 count=4. A6 is dropped and status=8'h4D. Output frames A1,A2,A3,A4,A5 are contiguous, each stop bit followed directly by a start bit.
4. Overflow clear: after scenario 3, store any value to FC -> bit3=0 on the next read. A subsequent store of 8'h00 to FD with the FIFO not full is accepted.
5. Reset mid-frame: pulse rst low during data bit 3 of 8'hF0 with 2 bytes queued -> tx=1 immediately, status=8'h02 after release, and no further frames.
6. Address decode: EN=1 with Address=10 and RegData=FF, and EN=0 with Address=FD -> no tx activity and count stays 0. Address=10 gives RdData=8'h00.
